// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: sequences PLL reset, qualifies lock stability and output
// frequency against the reference clock, and gates clk_ok to downstream logic.

module pll_sync_lane (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);
  logic [1:0] ff;

  always_ff @(posedge clk) begin
    if (!reset_n) ff <= '0;
    else          ff <= {ff[0], din};
  end

  assign dout = ff[1];
endmodule

module pll_lock_supervisor #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 27000,
  parameter int STABLE_CYCLES = 1024,
  parameter int WINDOW        = 4096,
  parameter int CNT_MIN       = 254,
  parameter int CNT_MAX       = 258,
  parameter int MAX_RETRY     = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        restart,
  input  logic        pll_locked,
  input  logic        meas_toggle,
  output logic        pll_rst,
  output logic        clk_ok,
  output logic        fail,
  output logic [3:0]  retry_cnt,
  output logic [15:0] meas_count,
  output logic [2:0]  state
);
  localparam int NUM_LANES = 2;
  localparam int LANE_LOCK = 0;
  localparam int LANE_TOG  = 1;

  localparam int CYC_MAX0 = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
  localparam int CYC_MAX  = (CYC_MAX0 > WINDOW) ? CYC_MAX0 : WINDOW;
  localparam int CW       = $clog2(CYC_MAX + 1);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    MEASURE   = 3'd3,
    RUN       = 3'd4,
    FAIL      = 3'd5
  } state_t;

  state_t                         st;
  logic [CW-1:0]                  cyc;
  logic [15:0]                    edges;
  logic [15:0]                    edges_nxt;
  logic [NUM_LANES-1:0]           async_in;
  logic [NUM_LANES-1:0]           sync_out;
  logic                           tog_d;
  logic                           tog_edge;
  logic                           lock;
  logic                           win_end;
  logic                           in_range;
  logic                           acq_fail;
  logic [3:0]                     retry_inc;
  logic                           retry_exhausted;

  // Both PLL-domain inputs share the same 2-FF synchroniser lane.
  assign async_in = {meas_toggle, pll_locked};

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_sync
      pll_sync_lane u_lane (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (async_in[g]),
        .dout    (sync_out[g])
      );
    end
  endgenerate

  assign lock     = sync_out[LANE_LOCK];
  assign tog_edge = sync_out[LANE_TOG] ^ tog_d;

  // Saturating edge accumulator; the value seen at window end includes the last cycle.
  assign edges_nxt = (edges == 16'hFFFF) ? edges : edges + 16'(tog_edge);
  assign win_end   = (cyc == CW'(WINDOW - 1));
  assign in_range  = (edges_nxt >= 16'(CNT_MIN)) && (edges_nxt <= 16'(CNT_MAX));

  assign retry_inc       = (retry_cnt == 4'hF) ? 4'hF : retry_cnt + 4'd1;
  assign retry_exhausted = (int'(retry_inc) >= MAX_RETRY);

  always_comb begin
    acq_fail = 1'b0;
    case (st)
      WAIT_LOCK: acq_fail = !lock && (cyc == CW'(LOCK_TIMEOUT - 1));
      STABLE:    acq_fail = !lock;
      MEASURE:   acq_fail = !lock || (win_end && !in_range);
      default:   acq_fail = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st         <= RESET_PLL;
      cyc        <= '0;
      edges      <= '0;
      tog_d      <= 1'b0;
      pll_rst    <= 1'b1;
      clk_ok     <= 1'b0;
      fail       <= 1'b0;
      retry_cnt  <= '0;
      meas_count <= '0;
    end else begin
      tog_d <= sync_out[LANE_TOG];
      if (restart) begin
        st        <= RESET_PLL;
        cyc       <= '0;
        pll_rst   <= 1'b1;
        clk_ok    <= 1'b0;
        fail      <= 1'b0;
        retry_cnt <= '0;
      end else if (acq_fail) begin
        // An out-of-range window still publishes its count; a lock drop does not.
        if (st == MEASURE && lock) meas_count <= edges_nxt;
        retry_cnt <= retry_inc;
        cyc       <= '0;
        pll_rst   <= 1'b1;
        clk_ok    <= 1'b0;
        if (retry_exhausted) begin
          st   <= FAIL;
          fail <= 1'b1;
        end else begin
          st   <= RESET_PLL;
        end
      end else begin
        case (st)
          RESET_PLL: begin
            if (cyc == CW'(RST_CYCLES - 1)) begin
              st      <= WAIT_LOCK;
              cyc     <= '0;
              pll_rst <= 1'b0;
            end else begin
              cyc <= cyc + 1'b1;
            end
          end
          WAIT_LOCK: begin
            if (lock) begin
              st  <= STABLE;
              cyc <= '0;
            end else begin
              cyc <= cyc + 1'b1;
            end
          end
          STABLE: begin
            if (cyc == CW'(STABLE_CYCLES - 1)) begin
              st    <= MEASURE;
              cyc   <= '0;
              edges <= '0;
            end else begin
              cyc <= cyc + 1'b1;
            end
          end
          MEASURE: begin
            if (win_end) begin
              st         <= RUN;
              cyc        <= '0;
              meas_count <= edges_nxt;
              retry_cnt  <= '0;
              clk_ok     <= 1'b1;
            end else begin
              cyc   <= cyc + 1'b1;
              edges <= edges_nxt;
            end
          end
          RUN: begin
            // Losing lock after qualification is not a failed acquisition.
            if (!lock) begin
              st      <= RESET_PLL;
              cyc     <= '0;
              pll_rst <= 1'b1;
              clk_ok  <= 1'b0;
            end
          end
          FAIL: begin
            pll_rst <= 1'b1;
            clk_ok  <= 1'b0;
            fail    <= 1'b1;
          end
          default: begin
            st      <= RESET_PLL;
            cyc     <= '0;
            pll_rst <= 1'b1;
            clk_ok  <= 1'b0;
            fail    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign state = st;

  a_clk_ok_run : assert property (@(posedge clk) disable iff (!reset_n)
    clk_ok == (st == RUN));
  a_rst_states : assert property (@(posedge clk) disable iff (!reset_n)
    pll_rst == (st == RESET_PLL || st == FAIL));
  a_fail_state : assert property (@(posedge clk) disable iff (!reset_n)
    fail == (st == FAIL));
endmodule
